gpio_atr_v2: RTL
================

# gpio_atr_v2

Parametrised automatic transmit/receive (ATR) GPIO controller for daughterboard control lines. It drives up to 32 pins from four per-state output words selected by the radio's `tx`/`rx` status. Beyond the fixed-function predecessor, it adds programmable TX-off and RX-off hold delays, per-pin ATR masking, and synchronised input readback with edge-detect interrupts. It sits on the settings bus beside the radio core; pad tristating is done at the top level from `gpio_out`/`gpio_oe`.

## Interface
- `BASE`, 0: first settings-bus address; the block uses BASE+0 .. BASE+10.
- `WIDTH`, 32: number of pins, 1..32.
- `DELAY_W`, 16: width of the hold-delay counters.

Ports:
- `clk` input 1: single clock domain for the block.
- `reset_n` input 1: reset, asynchronous, active-low.
- `set_stb` input 1: settings-bus write strobe.
- `set_addr` input 8: settings-bus address.
- `set_data` input 32: settings-bus data; bits above WIDTH are ignored.
- `rx` input 1: receive active.
- `tx` input 1: transmit active.
- `gpio_in` input WIDTH: raw pad inputs, asynchronous.
- `gpio_out` output WIDTH: registered pad output values.
- `gpio_oe` output WIDTH: pad output enables; this is the DDR register, 1 = drive.
- `gpio_readback` output 32: synchronised `gpio_in`, zero-extended.
- `irq_status` output WIDTH: sticky edge-event bits.
- `irq` output 1: OR of `irq_status`.
- `atr_state` output 2: effective state {tx_eff, rx_eff}.

## Operation
- The settings registers are written when `set_stb` is high and `set_addr` equals BASE+n. Each register resets to 0.
  - Register 0: IDLE.
  - Register 1: RX.
  - Register 2: TX.
  - Register 3: FDX.
  - Register 4: DDR.
  - Register 5: ATR_MASK. A 1 makes the pin follow ATR; a 0 makes the pin always use IDLE.
  - Register 6: TX_OFF_DELAY[DELAY_W-1:0].
  - Register 7: RX_OFF_DELAY.
  - Register 8: RISE_EN.
  - Register 9: FALL_EN.
  - Register 10: IRQ_CLEAR. This is write-1-to-clear and is not stored.
- Hold logic, independent for the tx and rx channels, each with a counter `cnt`:
  - If the input is high: `eff` is set to 1 and `cnt` to 0.
  - Else if `eff` is 1 and `cnt` >= DELAY: `eff` is set to 0 and `cnt` to 0.
  - Else if `eff` is 1: `cnt` increments.
  - If the input reasserts mid-count, the count restarts and `eff` stays 1.
  - If DELAY is rewritten mid-count, the comparison uses the new value. If DELAY is below the current count, `eff` drops on the next edge.
- `atr_state` is the registered {tx_eff, rx_eff}.
- Output select from `atr_state`: 00 → IDLE, 01 → RX, 10 → TX, 11 → FDX. Per pin, the output is `mask ? selected : IDLE`, and it is registered into `gpio_out`.
- `gpio_oe` equals DDR. `gpio_out` is driven even on pins where `gpio_oe` is 0.
- Input path:
  - A two-flop synchroniser produces `s`.
  - A one-cycle delayed copy produces `p`.
  - `gpio_readback` is {0, s}.
  - rise = s & ~p & RISE_EN; fall = ~s & p & FALL_EN.
  - Edges are detected on every pin regardless of DDR.
- Status update: `irq_status` <= (`irq_status` & ~clr) | rise | fall. An event arriving in the same cycle as a clear of the same bit wins, and the bit stays set.
- `irq` is the OR of the `irq_status` flops and is glitch-free.
- Reset state: all outputs are 0, all counters and eff flags are 0, and the synchroniser flops are 0.

## Timing
- `tx`/`rx` rising at edge k: `atr_state` updates at edge k, and `gpio_out` updates at edge k+1.
- Falling edge with DELAY = D: `atr_state` drops at edge k+D, and `gpio_out` follows at edge k+D+1.
- Register write at edge k: the new value is visible on `gpio_oe` after edge k. It reaches `gpio_out` after edge k+1.
- `gpio_in` change before edge k: `gpio_readback` reflects it after edge k+1. `irq_status` sets after edge k+2.
- Reset mid-hold clears the counters immediately. After release, the block restarts in IDLE.

## Structure
- Address offsets (0..10) and the ATR state encodings go in a shared include, `gpio_atr_defs.vh`.
- One sub-module, `atr_hold`, instantiated twice (tx, rx). It holds the counter, the eff flag, and the DELAY compare.
- The settings registers are internal flops, not `setting_reg`, because of the asynchronous active-low reset.

## Test plan
- Reset, then write IDLE = 0x1, TX = 0x2, MASK = 0xFFFFFFFF, DDR = 0xF. Pulse `tx` for 1 cycle. Required: `gpio_out` goes 0x2 one cycle after `atr_state` = 10, then returns to 0x1; `gpio_oe` = 0xF.
- Set TX_OFF_DELAY = 5 and drop `tx` at edge k. Required: `atr_state[1]` falls at k+5, `gpio_out` at k+6. Reassert `tx` at k+3: `atr_state` stays 10 with no glitch.
- Set `tx` = `rx` = 1 with FDX = 0xA5 and MASK = 0x0F. Required: `gpio_out` = (IDLE & 0xF0) | 0x05.
- Set RISE_EN = 0x1 and toggle `gpio_in[0]` 0→1. Required: `gpio_readback[0]` = 1 after 2 edges, and `irq_status` = 0x1 with `irq` = 1 one edge later. Write IRQ_CLEAR = 0x1: the bit clears. Repeat with the clear coinciding with a new edge: the bit stays set.
- Set TX_OFF_DELAY = 100, then rewrite it to 2 at count 10. Required: `tx_eff` drops on the next edge.
- Assert `reset_n` low mid-hold with `gpio_out` nonzero. Required: all outputs read 0 asynchronously, and the block operates normally after release.

Source files
------------

// File: rtl/gpio_atr_v2_pkg.sv
// Shared definitions for the ATR GPIO controller: register offsets and
// ATR state encodings.
package gpio_atr_v2_pkg;

  localparam logic [3:0] REG_IDLE     = 4'd0;
  localparam logic [3:0] REG_RX       = 4'd1;
  localparam logic [3:0] REG_TX       = 4'd2;
  localparam logic [3:0] REG_FDX      = 4'd3;
  localparam logic [3:0] REG_DDR      = 4'd4;
  localparam logic [3:0] REG_ATR_MASK = 4'd5;
  localparam logic [3:0] REG_TX_DLY   = 4'd6;
  localparam logic [3:0] REG_RX_DLY   = 4'd7;
  localparam logic [3:0] REG_RISE_EN  = 4'd8;
  localparam logic [3:0] REG_FALL_EN  = 4'd9;
  localparam logic [3:0] REG_IRQ_CLR  = 4'd10;

  // Effective ATR state, bit 1 = tx_eff, bit 0 = rx_eff.
  typedef enum logic [1:0] {
    ATR_IDLE = 2'b00,
    ATR_RX   = 2'b01,
    ATR_TX   = 2'b10,
    ATR_FDX  = 2'b11
  } atr_state_e;

  // True when the settings-bus address selects register BASE+off.
  function automatic logic addr_hit(input logic [7:0] addr,
                                    input int unsigned base,
                                    input logic [3:0] off);
    return addr == 8'(base + 32'(off));
  endfunction

endpackage

// File: rtl/gpio_atr_v2_if.sv
// Settings-bus write port shared by the radio core and the GPIO block.
interface gpio_atr_v2_if;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  modport master (output set_stb, output set_addr, output set_data);
  modport slave  (input  set_stb, input  set_addr, input  set_data);
endinterface

// File: rtl/gpio_atr_v2_atr_hold.sv
// Off-hold for one ATR channel: eff follows the input high immediately and
// stays high for DELAY further cycles after the input drops.
module atr_hold #(
  parameter int unsigned DELAY_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               eff_o
);

  logic               eff_q, eff_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;

  // Next-state: restart on input high, release once the live DELAY is reached.
  always_comb begin
    eff_d = eff_q;
    cnt_d = cnt_q;
    if (in_i) begin
      eff_d = 1'b1;
      cnt_d = '0;
    end else if (eff_q && (cnt_q >= delay_i)) begin
      eff_d = 1'b0;
      cnt_d = '0;
    end else if (eff_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Hold state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eff_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      eff_q <= eff_d;
      cnt_q <= cnt_d;
    end
  end

  assign eff_o = eff_q;

endmodule

// File: rtl/gpio_atr_v2.sv
// ATR GPIO controller: per-state output words with masking and off-hold
// delays, synchronised readback and sticky edge interrupts.
module gpio_atr_v2
  import gpio_atr_v2_pkg::*;
#(
  parameter int unsigned BASE    = 0,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DELAY_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_atr_v2_if.slave     sb,
  input  logic             rx,
  input  logic             tx,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [31:0]      gpio_readback,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq,
  output logic [1:0]       atr_state
);

  logic [WIDTH-1:0]   idle_q, rxw_q, txw_q, fdx_q, ddr_q, mask_q;
  logic [WIDTH-1:0]   rise_en_q, fall_en_q;
  logic [DELAY_W-1:0] tx_dly_q, rx_dly_q;

  logic [WIDTH-1:0]   data_w;
  logic [DELAY_W-1:0] dly_w;

  assign data_w = sb.set_data[WIDTH-1:0];
  assign dly_w  = sb.set_data[DELAY_W-1:0];

  // Settings registers written from the settings bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q    <= '0;
      rxw_q     <= '0;
      txw_q     <= '0;
      fdx_q     <= '0;
      ddr_q     <= '0;
      mask_q    <= '0;
      tx_dly_q  <= '0;
      rx_dly_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (sb.set_stb) begin
      if (addr_hit(sb.set_addr, BASE, REG_IDLE))     idle_q    <= data_w;
      if (addr_hit(sb.set_addr, BASE, REG_RX))       rxw_q     <= data_w;
      if (addr_hit(sb.set_addr, BASE, REG_TX))       txw_q     <= data_w;
      if (addr_hit(sb.set_addr, BASE, REG_FDX))      fdx_q     <= data_w;
      if (addr_hit(sb.set_addr, BASE, REG_DDR))      ddr_q     <= data_w;
      if (addr_hit(sb.set_addr, BASE, REG_ATR_MASK)) mask_q    <= data_w;
      if (addr_hit(sb.set_addr, BASE, REG_TX_DLY))   tx_dly_q  <= dly_w;
      if (addr_hit(sb.set_addr, BASE, REG_RX_DLY))   rx_dly_q  <= dly_w;
      if (addr_hit(sb.set_addr, BASE, REG_RISE_EN))  rise_en_q <= data_w;
      if (addr_hit(sb.set_addr, BASE, REG_FALL_EN))  fall_en_q <= data_w;
    end
  end

  logic tx_eff, rx_eff;

  atr_hold #(.DELAY_W(DELAY_W)) u_tx_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .in_i    (tx),
    .delay_i (tx_dly_q),
    .eff_o   (tx_eff)
  );

  atr_hold #(.DELAY_W(DELAY_W)) u_rx_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .in_i    (rx),
    .delay_i (rx_dly_q),
    .eff_o   (rx_eff)
  );

  atr_state_e       st;
  logic [WIDTH-1:0] sel, out_d, out_q;

  assign st = atr_state_e'({tx_eff, rx_eff});

  // Select the state word, then fall back to IDLE on unmasked pins.
  always_comb begin
    sel = idle_q;
    unique case (st)
      ATR_IDLE: sel = idle_q;
      ATR_RX:   sel = rxw_q;
      ATR_TX:   sel = txw_q;
      ATR_FDX:  sel = fdx_q;
    endcase
    out_d = (mask_q & sel) | (~mask_q & idle_q);
  end

  // Registered pad output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else          out_q <= out_d;
  end

  logic [WIDTH-1:0] sync1_q, s_q, p_q;
  logic [WIDTH-1:0] rise, fall, clr, irq_d, irq_q;
  logic             irq_or_q;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      s_q     <= '0;
      p_q     <= '0;
    end else begin
      sync1_q <= gpio_in;
      s_q     <= sync1_q;
      p_q     <= s_q;
    end
  end

  // Edge events and write-1-to-clear; a same-cycle event overrides its clear.
  always_comb begin
    rise  = s_q & ~p_q & rise_en_q;
    fall  = ~s_q & p_q & fall_en_q;
    clr   = '0;
    if (sb.set_stb && addr_hit(sb.set_addr, BASE, REG_IRQ_CLR)) clr = data_w;
    irq_d = (irq_q & ~clr) | rise | fall;
  end

  // The irq line is its own flop loaded with the OR of the next status, so it
  // tracks irq_status cycle for cycle without a combinational glitch path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q    <= '0;
      irq_or_q <= 1'b0;
    end else begin
      irq_q    <= irq_d;
      irq_or_q <= |irq_d;
    end
  end

  logic [31:0] rb;

  // Zero-extend the synchronised inputs to the 32-bit readback word.
  always_comb begin
    rb            = '0;
    rb[WIDTH-1:0] = s_q;
  end

  assign gpio_out      = out_q;
  assign gpio_oe       = ddr_q;
  assign gpio_readback = rb;
  assign irq_status    = irq_q;
  assign irq           = irq_or_q;
  assign atr_state     = {tx_eff, rx_eff};

endmodule
